// File: rtl/db_mv_ram_ctrl_pkg.sv
// Shared definitions for the deblocking MV store: RAM geometry, clear word
// and the controller state encoding.
package db_mv_ram_ctrl_pkg;

  localparam int MV_ADDR_W = 6;
  localparam int MV_DATA_W = 20;
  localparam int MV_DEPTH  = 64;

  localparam logic [MV_DATA_W-1:0] MV_CLR_VAL = 20'h0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } mv_state_t;

endpackage

// File: rtl/db_mv_ram_ctrl_if.sv
// Request/ack bus between the MV writer/reader and the MV RAM controller.
interface db_mv_ram_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 20
);
  logic              clr_start_i;
  logic              clr_busy_o;
  logic              clr_done_o;
  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_adr_i;
  logic [DATA_W-1:0] wr_dat_i;
  logic              wr_ack_o;
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_adr_i;
  logic              rd_ack_o;
  logic              rd_vld_o;
  logic [DATA_W-1:0] rd_dat_o;

  modport master (
    output clr_start_i, wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i,
    input  clr_busy_o, clr_done_o, wr_ack_o, rd_ack_o, rd_vld_o, rd_dat_o
  );

  modport slave (
    input  clr_start_i, wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i,
    output clr_busy_o, clr_done_o, wr_ack_o, rd_ack_o, rd_vld_o, rd_dat_o
  );
endinterface

// File: rtl/db_mv_ram_sp_64x20.sv
// Behavioural single-port MV RAM: active-low cen/wen, registered read data
// that holds its value on write and idle cycles.
module db_mv_ram_sp_64x20
  import db_mv_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = MV_ADDR_W,
  parameter int DATA_W = MV_DATA_W
) (
  input  logic              clk,
  input  logic              cen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [MV_DEPTH];

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[adr] <= d;
      else      q        <= mem[adr];
    end
  end

endmodule

// File: rtl/db_mv_ram_ctrl.sv
// MV RAM sequencer: round-robin arbitration of one write and one read port
// onto a single-port RAM, plus a 64-word clear sweep on request.
module db_mv_ram_ctrl
  import db_mv_ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = MV_ADDR_W,
  parameter int                DATA_W  = MV_DATA_W,
  parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(MV_CLR_VAL)
) (
  input logic             clk,
  input logic             rst,
  db_mv_ram_ctrl_if.slave bus
);

  mv_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_wr_q, last_wr_d;
  logic              rd_vld_p1;

  logic              wr_ack, rd_ack, clr_done;
  logic              ram_cen, ram_wen;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    clr_done  = 1'b0;
    ram_cen   = 1'b1;
    ram_wen   = 1'b1;
    ram_adr   = '0;
    ram_d     = bus.wr_dat_i;

    unique case (state_q)
      ST_IDLE: begin
        if (!rst) begin
          if (bus.wr_req_i && (!bus.rd_req_i || !last_wr_q)) wr_ack = 1'b1;
          else if (bus.rd_req_i)                            rd_ack = 1'b1;
        end
        if (wr_ack) begin
          ram_cen   = 1'b0;
          ram_wen   = 1'b0;
          ram_adr   = bus.wr_adr_i;
          last_wr_d = 1'b1;
        end else if (rd_ack) begin
          ram_cen   = 1'b0;
          ram_adr   = bus.rd_adr_i;
          last_wr_d = 1'b0;
        end
        if (bus.clr_start_i && !rst) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        ram_cen = 1'b0;
        ram_wen = 1'b0;
        ram_adr = cnt_q;
        ram_d   = CLR_VAL;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d  = ST_IDLE;
          clr_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Out of reset the pointer reads as "write granted last", so a read wins
  // the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b1;
      rd_vld_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      rd_vld_p1 <= rd_ack;
    end
  end

  // Stage p1: RAM Q register aligned with rd_vld_p1
  db_mv_ram_sp_64x20 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk (clk),
    .cen (ram_cen),
    .wen (ram_wen),
    .adr (ram_adr),
    .d   (ram_d),
    .q   (bus.rd_dat_o)
  );

  assign bus.wr_ack_o   = wr_ack;
  assign bus.rd_ack_o   = rd_ack;
  assign bus.clr_done_o = clr_done;
  assign bus.clr_busy_o = (state_q == ST_CLEAR);
  assign bus.rd_vld_o   = rd_vld_p1;

endmodule

// File: tb/tb_db_mv_ram_ctrl.sv
// Randomized bench for db_mv_ram_ctrl against a cycle-level reference model
// of the arbitration, clear sweep and RAM contents.
module tb_db_mv_ram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  db_mv_ram_ctrl_if #(.ADDR_W(6), .DATA_W(20)) bus ();

  db_mv_ram_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [19:0] m_mem   [64];
  bit          m_known [64];
  bit          m_clear;
  int          m_idx;
  bit          m_read_next;
  bit          m_vld;
  logic [19:0] m_rdat;
  bit          m_rdat_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear      = 1'b0;
    m_idx        = 0;
    m_read_next  = 1'b1;
    m_vld        = 1'b0;
    m_rdat_known = 1'b0;
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
  endtask

  // One clock cycle: drive, check at mid-cycle, advance the model at the edge.
  task automatic cycle(input logic wr, input logic [5:0] wa, input logic [19:0] wd,
                       input logic rd, input logic [5:0] ra, input logic clr);
    logic e_wr, e_rd, e_done;
    bus.wr_req_i    = wr;
    bus.wr_adr_i    = wa;
    bus.wr_dat_i    = wd;
    bus.rd_req_i    = rd;
    bus.rd_adr_i    = ra;
    bus.clr_start_i = clr;
    if (m_clear) begin
      e_wr   = 1'b0;
      e_rd   = 1'b0;
      e_done = (m_idx == 63);
    end else begin
      e_done = 1'b0;
      if (wr && rd) begin
        e_rd = m_read_next;
        e_wr = !m_read_next;
      end else begin
        e_wr = wr;
        e_rd = rd;
      end
    end
    #4;
    chk("wr_ack", bus.wr_ack_o, e_wr);
    chk("rd_ack", bus.rd_ack_o, e_rd);
    chk("clr_busy", bus.clr_busy_o, m_clear);
    chk("clr_done", bus.clr_done_o, e_done);
    chk("rd_vld", bus.rd_vld_o, m_vld);
    if (m_vld && m_rdat_known) chk("rd_dat", bus.rd_dat_o, m_rdat);
    @(posedge clk);
    m_vld = e_rd;
    if (e_rd) begin
      m_rdat       = m_mem[ra];
      m_rdat_known = m_known[ra];
      m_read_next  = 1'b0;
    end
    if (m_clear) begin
      m_mem[m_idx]   = 20'h0;
      m_known[m_idx] = 1'b1;
      if (m_idx == 63) m_clear = 1'b0;
      m_idx++;
    end else begin
      if (e_wr) begin
        m_mem[wa]   = wd;
        m_known[wa] = 1'b1;
        m_read_next = 1'b1;
      end
      if (clr) begin
        m_clear = 1'b1;
        m_idx   = 0;
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 6'd0, 20'd0, 1'b0, 6'd0, 1'b0);
  endtask

  // Reset with both requests held high: acks must stay low.
  task automatic do_reset();
    rst             = 1'b1;
    bus.wr_req_i    = 1'b1;
    bus.rd_req_i    = 1'b1;
    bus.wr_adr_i    = 6'd1;
    bus.rd_adr_i    = 6'd2;
    bus.wr_dat_i    = 20'h12345;
    bus.clr_start_i = 1'b0;
    model_reset();
    #1;
    chk("rst_wr_ack", bus.wr_ack_o, 1'b0);
    chk("rst_rd_ack", bus.rd_ack_o, 1'b0);
    chk("rst_busy", bus.clr_busy_o, 1'b0);
    chk("rst_done", bus.clr_done_o, 1'b0);
    chk("rst_vld", bus.rd_vld_o, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [19:0] wd;
    @(posedge clk);
    #1;
    do_reset();

    // single write then read-back
    cycle(1'b1, 6'd5, 20'hABCDE, 1'b0, 6'd0, 1'b0);
    cycle(1'b0, 6'd0, 20'd0, 1'b1, 6'd5, 1'b0);
    idle_cycle();

    // continuous contention from reset: R,W,R,W,R,W
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 6'(10 + i), 20'(i * 7 + 3), 1'b1, 6'd5, 1'b0);
    idle_cycle();

    // fill with ones, then clear with a write raised in the first sweep cycle
    // and a second start pulse mid-sweep
    for (int a = 0; a < 64; a++) cycle(1'b1, 6'(a), 20'hFFFFF, 1'b0, 6'd0, 1'b0);
    cycle(1'b0, 6'd0, 20'd0, 1'b1, 6'd7, 1'b1);
    for (int c = 0; c < 64; c++) cycle(1'b1, 6'd33, 20'h5A5A5, 1'b0, 6'd0, (c == 30));
    idle_cycle();
    for (int a = 0; a < 64; a++) cycle(1'b0, 6'd0, 20'd0, 1'b1, 6'(a), 1'b0);
    idle_cycle();

    // randomized traffic with occasional clear pulses
    for (int i = 0; i < 600; i++) begin
      wd = 20'($urandom);
      cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), wd,
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
            ($urandom_range(0, 149) == 0));
    end
    for (int i = 0; i < 70; i++) idle_cycle();

    // reset at sweep cycle 20 aborts the sweep
    cycle(1'b0, 6'd0, 20'd0, 1'b1, 6'd3, 1'b1);
    for (int c = 0; c < 20; c++) idle_cycle();
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.clr_busy_o, 1'b0);
    chk("abort_vld", bus.rd_vld_o, 1'b0);
    chk("abort_done", bus.clr_done_o, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 50; c++) idle_cycle();
    cycle(1'b1, 6'd9, 20'h13579, 1'b0, 6'd0, 1'b0);
    cycle(1'b0, 6'd0, 20'd0, 1'b1, 6'd9, 1'b0);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
